// File: rtl/pc_next_unit_pkg.sv
// rtl/pc_next_unit_pkg.sv - shared constants and state type for the PC stage
package pc_next_unit_pkg;

   localparam int          WIDTH            = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } pc_state_t;

endpackage

// File: rtl/pc_next_unit_adder32.sv
// rtl/pc_next_unit_adder32.sv - 32-bit ripple-carry adder built from 1-bit full adders
module adder32
   import pc_next_unit_pkg::*;
(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_s,
   output logic             o_cout
);

   logic [WIDTH:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter with jump/branch redirect, fetch handshake and halt
module pc_next_unit
   import pc_next_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_fetch_ready,
   input  logic        i_stall,
   input  logic        i_jump,
   input  logic [25:0] i_jump_index,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_offset,
   input  logic        i_halt,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_pc_valid,
   output logic        o_flush,
   output logic        o_wrap
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   pc_state_t   r_state;
   pc_state_t   w_next_state;
   logic [31:0] r_pc;
   logic        r_pc_valid;
   logic        r_flush;
   logic        r_wrap;

   logic [31:0] w_next_pc;
   logic        w_next_flush;
   logic        w_next_wrap;
   logic [31:0] w_pc_plus4;
   logic        w_seq_carry;
   logic [31:0] w_branch_target;
   logic        w_br_cout;
   logic [31:0] w_jump_target;
   logic        w_unused;

   adder32 u_add_seq (
      .i_a    (r_pc),
      .i_b    (PC_INC),
      .i_cin  (1'b0),
      .o_s    (w_pc_plus4),
      .o_cout (w_seq_carry)
   );

   adder32 u_add_branch (
      .i_a    (w_pc_plus4),
      .i_b    ({i_branch_offset[29:0], 2'b00}),
      .i_cin  (1'b0),
      .o_s    (w_branch_target),
      .o_cout (w_br_cout)
   );

   // Branch carry and the top offset bits are discarded: targets wrap modulo 2^32.
   assign w_unused      = ^{w_br_cout, i_branch_offset[31:30]};
   assign w_jump_target = {w_pc_plus4[31:28], i_jump_index, 2'b00};

   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_next_flush = 1'b0;
      w_next_wrap  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_next_state = i_halt ? ST_HALT : ST_RUN;
         end
         ST_RUN: begin
            if (i_halt) begin
               w_next_state = ST_HALT;
            end else if (i_jump) begin
               w_next_pc    = w_jump_target;
               w_next_flush = 1'b1;
               w_next_state = ST_FLUSH;
            end else if (i_branch_taken) begin
               w_next_pc    = w_branch_target;
               w_next_flush = 1'b1;
               w_next_state = ST_FLUSH;
            end else if (r_pc_valid && i_fetch_ready && !i_stall) begin
               w_next_pc   = w_pc_plus4;
               w_next_wrap = w_seq_carry;
            end
         end
         ST_FLUSH: begin
            w_next_state = i_halt ? ST_HALT : ST_RUN;
         end
         ST_HALT: begin
            w_next_state = ST_HALT;
         end
         default: begin
            w_next_state = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_pc       <= RESET_PC_ALIGNED;
         r_pc_valid <= 1'b0;
         r_flush    <= 1'b0;
         r_wrap     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_pc       <= w_next_pc;
         r_pc_valid <= (w_next_state == ST_RUN);
         r_flush    <= w_next_flush;
         r_wrap     <= w_next_wrap;
      end
   end

   assign o_pc       = r_pc;
   assign o_pc_plus4 = w_pc_plus4;
   assign o_pc_valid = r_pc_valid;
   assign o_flush    = r_flush;
   assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed self-checking bench for pc_next_unit
`timescale 1ns/1ps
module tb_pc_next_unit;

   logic        clk;
   logic        rst_n, rst_n_b;
   logic        fetch_ready, stall, jump, branch_taken, halt;
   logic [25:0] jump_index;
   logic [31:0] branch_offset;
   logic [31:0] pc, pc_plus4, pc_b, pc_plus4_b;
   logic        pc_valid, flush, wrap, pc_valid_b, flush_b, wrap_b;

   int n_tests = 0;
   int n_fail  = 0;

   pc_next_unit u_dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_fetch_ready   (fetch_ready),
      .i_stall         (stall),
      .i_jump          (jump),
      .i_jump_index    (jump_index),
      .i_branch_taken  (branch_taken),
      .i_branch_offset (branch_offset),
      .i_halt          (halt),
      .o_pc            (pc),
      .o_pc_plus4      (pc_plus4),
      .o_pc_valid      (pc_valid),
      .o_flush         (flush),
      .o_wrap          (wrap)
   );

   pc_next_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .i_clk           (clk),
      .i_rst_n         (rst_n_b),
      .i_fetch_ready   (1'b1),
      .i_stall         (1'b0),
      .i_jump          (1'b0),
      .i_jump_index    (26'd0),
      .i_branch_taken  (1'b0),
      .i_branch_offset (32'd0),
      .i_halt          (1'b0),
      .o_pc            (pc_b),
      .o_pc_plus4      (pc_plus4_b),
      .o_pc_valid      (pc_valid_b),
      .o_flush         (flush_b),
      .o_wrap          (wrap_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; rst_n_b = 1'b0;
      fetch_ready = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;
      jump_index = '0; branch_offset = '0;
      tick(); tick();
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'd0, pc_valid}, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_wrap", {31'd0, wrap}, 32'd0);
      check("rst_plus4", pc_plus4, 32'h4);

      // reset release and sequential fetch
      rst_n = 1'b1;
      tick();
      check("t1_valid", {31'd0, pc_valid}, 32'd1);
      check("t1_pc0", pc, 32'h0);
      tick(); check("t1_pc4", pc, 32'h4);
      tick(); check("t1_pc8", pc, 32'h8);

      // stall holds the pc
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_hold_pc", pc, 32'h8);
         check("t2_hold_valid", {31'd0, pc_valid}, 32'd1);
      end
      stall = 1'b0;
      tick(); check("t2_resume", pc, 32'hC);

      // branch from 0xC to 0x1000_0010 (0x10 + 0x1000_0000)
      branch_taken = 1'b1; branch_offset = 32'h0400_0000;
      tick(); branch_taken = 1'b0;
      check("t3_br_pc", pc, 32'h1000_0010);
      check("t3_br_flush", {31'd0, flush}, 32'd1);
      tick();
      check("t3_br_run", pc, 32'h1000_0010);
      // jump at 0x1000_0010
      jump = 1'b1; jump_index = 26'h000_0040;
      tick(); jump = 1'b0;
      check("t3_j_pc", pc, 32'h1000_0100);
      check("t3_j_flush", {31'd0, flush}, 32'd1);
      check("t3_j_valid", {31'd0, pc_valid}, 32'd0);
      tick();
      check("t3_run_valid", {31'd0, pc_valid}, 32'd1);
      check("t3_run_flush", {31'd0, flush}, 32'd0);
      check("t3_run_pc", pc, 32'h1000_0100);
      tick(); check("t3_adv", pc, 32'h1000_0104);

      // branch with carry dropped: 0x1000_0108 + 0xEFFF_FF18 -> 0x20
      fetch_ready = 1'b0;
      branch_taken = 1'b1; branch_offset = 32'h3BFF_FFC6;
      tick(); branch_taken = 1'b0;
      check("t4_carry_pc", pc, 32'h20);
      tick();
      check("t4_hold_run", pc, 32'h20);
      branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
      tick(); branch_taken = 1'b0;
      check("t4_neg_pc", pc, 32'h1C);
      check("t4_neg_flush", {31'd0, flush}, 32'd1);
      check("t4_neg_wrap", {31'd0, wrap}, 32'd0);
      tick();
      check("t4_flush_clr", {31'd0, flush}, 32'd0);
      jump = 1'b1; jump_index = 26'h000_0100; branch_taken = 1'b1; branch_offset = 32'h4;
      tick(); jump = 1'b0; branch_taken = 1'b0;
      check("t4_prio_pc", pc, 32'h400);
      tick();
      check("t4_prio_valid", {31'd0, pc_valid}, 32'd1);

      // halt together with jump
      fetch_ready = 1'b1;
      halt = 1'b1; jump = 1'b1; jump_index = 26'h000_0200;
      tick(); jump = 1'b0; halt = 1'b0;
      check("t6_halt_pc", pc, 32'h400);
      check("t6_halt_flush", {31'd0, flush}, 32'd0);
      check("t6_halt_valid", {31'd0, pc_valid}, 32'd0);
      branch_taken = 1'b1; branch_offset = 32'h10;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_frozen_pc", pc, 32'h400);
         check("t6_frozen_valid", {31'd0, pc_valid}, 32'd0);
      end
      branch_taken = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_pc", pc, 32'h0);
      check("t6_async_valid", {31'd0, pc_valid}, 32'd0);
      tick(); rst_n = 1'b1;
      tick();
      check("t6_rerun_valid", {31'd0, pc_valid}, 32'd1);
      check("t6_rerun_pc", pc, 32'h0);

      // wrap with RESET_PC = 0xFFFF_FFF8
      check("t5_rst_pc", pc_b, 32'hFFFF_FFF8);
      rst_n_b = 1'b1;
      tick();
      check("t5_pc0", pc_b, 32'hFFFF_FFF8);
      check("t5_wrap0", {31'd0, wrap_b}, 32'd0);
      tick();
      check("t5_pc1", pc_b, 32'hFFFF_FFFC);
      check("t5_wrap1", {31'd0, wrap_b}, 32'd0);
      tick();
      check("t5_pc2", pc_b, 32'h0);
      check("t5_wrap2", {31'd0, wrap_b}, 32'd1);
      tick();
      check("t5_pc3", pc_b, 32'h4);
      check("t5_wrap3", {31'd0, wrap_b}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
